// File: rtl/real_table_streamer.sv
// real_table_streamer: fills a lookup table whose depth, step and traversal
// order are derived from real-valued parameters, then streams every entry
// out over a valid/ready interface with a one-cycle done pulse at the end.
module real_table_streamer #(
  parameter real DEPTH_REAL = 4.0,
  parameter real STEP_REAL  = 2.0,
  parameter int  WIDTH      = 8,
  parameter real THRESHOLD  = 3.5,
  parameter int  IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             busy,
  output logic             done
);

  // Real parameters truncate toward zero at elaboration.
  localparam int DEPTH = $rtoi(DEPTH_REAL);
  localparam int STEP  = $rtoi(STEP_REAL);

  // Address width actually needed to index the table; IDX_W may be wider.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  logic [1:0]       state;
  logic [IDX_W-1:0] k;
  logic [31:0]      fill_prod;
  logic [WIDTH-1:0] fill_val;

  // Order-dependent pointer control, chosen once at elaboration.
  logic [IDX_W-1:0] first_ptr;
  logic [IDX_W-1:0] last_ptr;
  logic [IDX_W-1:0] next_ptr;

  generate
    if (THRESHOLD > 3.0) begin : g_ascending
      assign first_ptr = '0;
      assign last_ptr  = LAST_K;
      assign next_ptr  = out_index + IDX_W'(1);
    end else begin : g_descending
      assign first_ptr = LAST_K;
      assign last_ptr  = '0;
      assign next_ptr  = out_index - IDX_W'(1);
    end
  endgenerate

  // Entry value: product formed in 32 bits, then truncated to the entry width.
  assign fill_prod = 32'(k) * 32'(STEP);
  assign fill_val  = fill_prod[WIDTH-1:0];

  assign busy = (state == S_FILL) || (state == S_STREAM);
  assign done = (state == S_DONE);

  // Table write port: one entry per FILL cycle.
  // NOTE: the table is deliberately left out of reset; every entry is
  // rewritten during FILL before it can be read, so a reset would only add
  // fan-out and block RAM inference.
  always_ff @(posedge clk) begin
    if (!rst && state == S_FILL) begin
      mem[k[AW-1:0]] <= fill_val;
    end
  end

  // Sequencer: IDLE -> FILL -> STREAM -> DONE, with registered stream outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FILL;
            k     <= '0;
          end
        end

        S_FILL: begin
          if (k == LAST_K) begin
            // The first streamed entry may be the one being written this
            // very cycle (descending order, or a single-entry table), so
            // it is forwarded from the write data instead of the array.
            state     <= S_STREAM;
            k         <= '0;
            out_valid <= 1'b1;
            out_index <= first_ptr;
            out_data  <= (first_ptr == k) ? fill_val : mem[first_ptr[AW-1:0]];
          end else begin
            k <= k + IDX_W'(1);
          end
        end

        S_STREAM: begin
          if (out_valid && out_ready) begin
            if (out_index == last_ptr) begin
              state     <= S_DONE;
              out_valid <= 1'b0;
            end else begin
              out_index <= next_ptr;
              out_data  <= mem[next_ptr[AW-1:0]];
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_real_table_streamer.sv
// Testbench for real_table_streamer: four parameterisations (defaults,
// fractional depth/step, descending order, wrapping step) checked against a
// hand-derived table of expected entries fed through a scoreboard queue.
module tb_real_table_streamer;

  localparam int NU = 4;

  typedef struct {
    int u;
    int idx;
    int data;
  } vec_t;

  typedef struct {
    int idx;
    int data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [NU];
  logic       ready [NU];
  logic       ov    [NU];
  logic [7:0] od    [NU];
  logic [3:0] oi    [NU];
  logic       bz    [NU];
  logic       dn    [NU];

  int   total = 0;
  int   bad   = 0;
  vec_t vecs [24];
  int   nvec = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  real_table_streamer u0 (
    .clk(clk), .rst(rst), .start(start[0]), .out_valid(ov[0]), .out_ready(ready[0]),
    .out_data(od[0]), .out_index(oi[0]), .busy(bz[0]), .done(dn[0])
  );

  real_table_streamer #(.DEPTH_REAL(8.5), .STEP_REAL(3.9)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .out_valid(ov[1]), .out_ready(ready[1]),
    .out_data(od[1]), .out_index(oi[1]), .busy(bz[1]), .done(dn[1])
  );

  real_table_streamer #(.THRESHOLD(2.0)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .out_valid(ov[2]), .out_ready(ready[2]),
    .out_data(od[2]), .out_index(oi[2]), .busy(bz[2]), .done(dn[2])
  );

  real_table_streamer #(.STEP_REAL(100.9)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .out_valid(ov[3]), .out_ready(ready[3]),
    .out_data(od[3]), .out_index(oi[3]), .busy(bz[3]), .done(dn[3])
  );

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, actual, expected);
    end
  endtask

  // Advance one clock; observe and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input int u, input int idx, input int data);
    vecs[nvec].u    = u;
    vecs[nvec].idx  = idx;
    vecs[nvec].data = data;
    nvec++;
  endfunction

  // Queue the expected entries of one unit, in stream order.
  function automatic void push_cfg(input int u);
    exp_t e;
    for (int i = 0; i < nvec; i++) begin
      if (vecs[i].u == u) begin
        e.idx  = vecs[i].idx;
        e.data = vecs[i].data;
        sb.push_back(e);
      end
    end
  endfunction

  // Called while a transfer is about to happen at the next edge.
  task automatic sb_pop_check(input int u);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_underflow: unit %0d got index %0d data %0d want nothing", u, oi[u], od[u]);
    end else begin
      e = sb.pop_front();
      check($sformatf("u%0d_index", u), int'(oi[u]), e.idx);
      check($sformatf("u%0d_data", u), int'(od[u]), e.data);
    end
  endtask

  // Consume transfers until done is seen; n counts edges since start.
  task automatic drain(input int u, inout int n);
    while (!dn[u] && n < 256) begin
      if (ov[u] && ready[u]) sb_pop_check(u);
      step();
      n++;
    end
    check($sformatf("u%0d_done_seen", u), int'(dn[u]), 1);
    check($sformatf("u%0d_busy_in_done", u), int'(bz[u]), 0);
    check($sformatf("u%0d_valid_in_done", u), int'(ov[u]), 0);
    step();
    check($sformatf("u%0d_done_one_cycle", u), int'(dn[u]), 0);
  endtask

  // Full pass with out_ready high; checks latencies and scoreboard drain.
  task automatic run_pass(input int u, input int d, input bit hold);
    int n;
    push_cfg(u);
    start[u] = 1'b1;
    ready[u] = 1'b1;
    step();
    if (!hold) start[u] = 1'b0;
    check($sformatf("u%0d_busy_fill", u), int'(bz[u]), 1);
    check($sformatf("u%0d_no_valid_fill", u), int'(ov[u]), 0);
    n = 0;
    while (!ov[u] && n < 64) begin
      step();
      n++;
    end
    check($sformatf("u%0d_first_valid_lat", u), n, d);
    drain(u, n);
    check($sformatf("u%0d_done_lat", u), n, 2 * d);
    check($sformatf("u%0d_sb_empty", u), sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Expected entries, derived by hand from depth/step/order.
    add(0, 0, 0);   add(0, 1, 2);   add(0, 2, 4);   add(0, 3, 6);
    add(1, 0, 0);   add(1, 1, 3);   add(1, 2, 6);   add(1, 3, 9);
    add(1, 4, 12);  add(1, 5, 15);  add(1, 6, 18);  add(1, 7, 21);
    add(2, 3, 6);   add(2, 2, 4);   add(2, 1, 2);   add(2, 0, 0);
    add(3, 0, 0);   add(3, 1, 100); add(3, 2, 200); add(3, 3, 44);

    rst = 1'b1;
    for (int u = 0; u < NU; u++) begin
      start[u] = 1'b0;
      ready[u] = 1'b1;
    end
    step();
    step();
    for (int u = 0; u < NU; u++) begin
      check($sformatf("u%0d_rst_valid", u), int'(ov[u]), 0);
      check($sformatf("u%0d_rst_busy", u), int'(bz[u]), 0);
      check($sformatf("u%0d_rst_done", u), int'(dn[u]), 0);
      check($sformatf("u%0d_rst_data", u), int'(od[u]), 0);
      check($sformatf("u%0d_rst_index", u), int'(oi[u]), 0);
    end
    rst = 1'b0;
    step();

    // Table-driven passes over every parameterisation.
    run_pass(0, 4, 1'b0);
    run_pass(1, 8, 1'b0);
    run_pass(2, 4, 1'b0);
    run_pass(3, 4, 1'b0);

    // Backpressure on entry (1,2), with a start pulse mid-stream.
    push_cfg(0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 64) begin
      step();
      n++;
    end
    check("bp_first_valid_lat", n, 4);
    sb_pop_check(0);
    step();
    ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", int'(ov[0]), 1);
      check("bp_hold_index", int'(oi[0]), 1);
      check("bp_hold_data", int'(od[0]), 2);
      start[0] = (i == 1);
      step();
    end
    start[0] = 1'b0;
    ready[0] = 1'b1;
    n = 0;
    drain(0, n);
    check("bp_sb_empty", sb.size(), 0);
    step();
    check("bp_no_restart", int'(bz[0]), 0);

    // Reset after two transfers, then a clean replay.
    push_cfg(0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 64) begin
      step();
      n++;
    end
    sb_pop_check(0);
    step();
    sb_pop_check(0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", int'(ov[0]), 0);
    check("mid_rst_busy", int'(bz[0]), 0);
    check("mid_rst_done", int'(dn[0]), 0);
    check("mid_rst_data", int'(od[0]), 0);
    check("mid_rst_index", int'(oi[0]), 0);
    sb.delete();
    step();
    run_pass(0, 4, 1'b0);

    // Start held high: a new pass begins on the first IDLE cycle after DONE.
    run_pass(0, 4, 1'b1);
    check("hold_idle_after_done", int'(bz[0]), 0);
    step();
    check("hold_restart_busy", int'(bz[0]), 1);
    start[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
